// File: rtl/mem_line_responder.sv
// Memory-side target for the L1 cache refill/writeback buses.
// It handles one line read or one byte-masked line write at a time, waits a
// programmable latency, then presents the response until the cache takes it.
module mem_line_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r_req_valid,
  output logic         r_req_ready,
  input  logic [31:0]  r_req,
  output logic         r_resp_valid,
  input  logic         r_resp_ready,
  output logic [129:0] r_resp,
  input  logic         w_req_valid,
  output logic         w_req_ready,
  input  logic [175:0] w_req,
  output logic         w_resp_valid,
  input  logic         w_resp_ready,
  output logic [1:0]   w_resp
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, R_WAIT, R_RESP, W_WAIT, W_RESP} state_t;

  state_t         state_reg;
  logic [7:0]     cnt_reg;
  logic [31:4]    addr_reg;
  logic [127:0]   wdata_reg;
  logic [15:0]    wmask_reg;
  logic           r_resp_valid_reg;
  logic           w_resp_valid_reg;
  logic [129:0]   r_resp_reg;
  logic [1:0]     w_resp_reg;

  // Line storage; contents survive reset.
  logic [127:0]   mem [DEPTH];

  logic [IW-1:0]  line_idx;
  logic           in_range;
  logic           w_accept;
  logic           r_accept;
  logic           wr_commit;
  logic           rd_sample;
  logic           unused_addr_bits;

  // Byte offset within a line carries no meaning for whole-line transfers.
  assign unused_addr_bits = ^{r_req[3:0], w_req[147:144]};

  assign line_idx = addr_reg[4 +: IW];
  assign in_range = (addr_reg[31:4+IW] == '0);

  // Write has priority: the read ready drops whenever a write is offered.
  assign w_req_ready = (state_reg == IDLE) && !rst;
  assign r_req_ready = (state_reg == IDLE) && !rst && !w_req_valid;
  assign w_accept    = w_req_valid && w_req_ready;
  assign r_accept    = r_req_valid && r_req_ready;

  assign wr_commit = !rst && (state_reg == W_WAIT) && (cnt_reg == 8'd0) && in_range;
  assign rd_sample = (state_reg == R_WAIT) && (cnt_reg == 8'd0);

  assign r_resp_valid = r_resp_valid_reg;
  assign w_resp_valid = w_resp_valid_reg;
  assign r_resp       = r_resp_reg;
  assign w_resp       = w_resp_reg;

  // Byte-masked line update, committed as the write leaves its wait phase.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int b = 0; b < 16; b++) begin
        if (wmask_reg[b]) begin
          mem[line_idx][8*b +: 8] <= wdata_reg[8*b +: 8];
        end
      end
    end
  end

  // Transaction sequencer: accept, count down latency, hold response until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      cnt_reg          <= 8'd0;
      addr_reg         <= '0;
      wdata_reg        <= '0;
      wmask_reg        <= '0;
      r_resp_valid_reg <= 1'b0;
      w_resp_valid_reg <= 1'b0;
      r_resp_reg       <= '0;
      w_resp_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (w_accept) begin
            addr_reg  <= w_req[175:148];
            wdata_reg <= w_req[143:16];
            wmask_reg <= w_req[15:0];
            cnt_reg   <= LAT_LOAD;
            state_reg <= W_WAIT;
          end else if (r_accept) begin
            addr_reg  <= r_req[31:4];
            cnt_reg   <= LAT_LOAD;
            state_reg <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rd_sample) begin
            r_resp_reg       <= in_range ? {mem[line_idx], RESP_OKAY} : {128'd0, RESP_SLVERR};
            r_resp_valid_reg <= 1'b1;
            state_reg        <= R_RESP;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end
        R_RESP: begin
          if (r_resp_ready) begin
            r_resp_valid_reg <= 1'b0;
            state_reg        <= IDLE;
          end
        end
        W_WAIT: begin
          if (cnt_reg == 8'd0) begin
            w_resp_reg       <= in_range ? RESP_OKAY : RESP_SLVERR;
            w_resp_valid_reg <= 1'b1;
            state_reg        <= W_RESP;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end
        W_RESP: begin
          if (w_resp_ready) begin
            w_resp_valid_reg <= 1'b0;
            state_reg        <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Only one response channel may be active at a time.
  a_one_resp: assert property (@(posedge clk) disable iff (rst)
    !(r_resp_valid && w_resp_valid));

  // A pending read response keeps valid and payload until it is taken.
  a_r_stable: assert property (@(posedge clk) disable iff (rst)
    (r_resp_valid && !r_resp_ready) |=> (r_resp_valid && $stable(r_resp)));

  // A pending write response keeps valid and payload until it is taken.
  a_w_stable: assert property (@(posedge clk) disable iff (rst)
    (w_resp_valid && !w_resp_ready) |=> (w_resp_valid && $stable(w_resp)));

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder with DEPTH=256, LATENCY=4.
module tb_mem_line_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         r_req_valid;
  logic         r_req_ready;
  logic [31:0]  r_req;
  logic         r_resp_valid;
  logic         r_resp_ready;
  logic [129:0] r_resp;
  logic         w_req_valid;
  logic         w_req_ready;
  logic [175:0] w_req;
  logic         w_resp_valid;
  logic         w_resp_ready;
  logic [1:0]   w_resp;

  int total = 0;
  int bad = 0;

  mem_line_responder #(.DEPTH(256), .LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req(r_req),
    .r_resp_valid(r_resp_valid), .r_resp_ready(r_resp_ready), .r_resp(r_resp),
    .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_req(w_req),
    .w_resp_valid(w_resp_valid), .w_resp_ready(w_resp_ready), .w_resp(w_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_write;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
    logic [1:0]   exp_code;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  localparam logic [127:0] D1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] A5  = {16{8'hA5}};
  localparam logic [127:0] K0  = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
  localparam logic [127:0] K3  = 128'h33333333_44444444_55555555_66666666;

  task automatic chk(input string name, input logic [129:0] act, input logic [129:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit is_write);
    int n = 0;
    while (!(is_write ? w_req_ready : r_req_ready) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [127:0] data,
                          input logic [15:0] mask, output int lat, output logic [1:0] code);
    w_req_valid = 1'b1;
    w_req = {addr, data, mask};
    #1;
    wait_ready(1'b1);
    tick();
    w_req_valid = 1'b0;
    lat = 0;
    while (!w_resp_valid && lat < 50) begin
      tick();
      lat++;
    end
    code = w_resp;
    w_resp_ready = 1'b1;
    tick();
    w_resp_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output int lat,
                         output logic [1:0] code, output logic [127:0] rdata);
    r_req_valid = 1'b1;
    r_req = addr;
    #1;
    wait_ready(1'b0);
    tick();
    r_req_valid = 1'b0;
    lat = 0;
    while (!r_resp_valid && lat < 50) begin
      tick();
      lat++;
    end
    code = r_resp[1:0];
    rdata = r_resp[129:2];
    r_resp_ready = 1'b1;
    tick();
    r_resp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    logic [1:0] code;
    logic [127:0] rdata;
    logic seen;

    vecs[0]  = '{1'b1, 32'h0000_0010, D1,   16'hFFFF, 2'b00, 128'd0};
    vecs[1]  = '{1'b0, 32'h0000_001C, '0,   16'h0,    2'b00, D1};
    vecs[2]  = '{1'b1, 32'h0000_0010, ONES, 16'h0003, 2'b00, 128'd0};
    vecs[3]  = '{1'b0, 32'h0000_0010, '0,   16'h0,    2'b00, 128'h00112233_44556677_8899AABB_CCDDFFFF};
    vecs[4]  = '{1'b1, 32'h0000_0070, '0,   16'hFFFF, 2'b00, 128'd0};
    vecs[5]  = '{1'b1, 32'h0000_0070, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 16'hF0F0, 2'b00, 128'd0};
    vecs[6]  = '{1'b0, 32'h0000_0075, '0,   16'h0,    2'b00, 128'h01234567_00000000_FEDCBA98_00000000};
    vecs[7]  = '{1'b1, 32'h0000_0000, K0,   16'hFFFF, 2'b00, 128'd0};
    vecs[8]  = '{1'b1, 32'h0000_1000, ONES, 16'hFFFF, 2'b10, 128'd0};
    vecs[9]  = '{1'b0, 32'h0000_1000, '0,   16'h0,    2'b10, 128'd0};
    vecs[10] = '{1'b0, 32'h0000_0000, '0,   16'h0,    2'b00, K0};
    vecs[11] = '{1'b1, 32'h0000_0FF0, D1,   16'hFFFF, 2'b00, 128'd0};
    vecs[12] = '{1'b0, 32'h0000_0FFF, '0,   16'h0,    2'b00, D1};
    vecs[13] = '{1'b0, 32'h8000_0000, '0,   16'h0,    2'b10, 128'd0};

    rst = 1'b1;
    r_req_valid = 1'b0; r_req = '0; r_resp_ready = 1'b0;
    w_req_valid = 1'b0; w_req = '0; w_resp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_w_req_ready", 130'(w_req_ready), 130'd0);
    chk("rst_r_req_ready", 130'(r_req_ready), 130'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_w_req_ready", 130'(w_req_ready), 130'd1);
    chk("post_rst_r_req_ready", 130'(r_req_ready), 130'd1);
    chk("post_rst_valids", 130'({r_resp_valid, w_resp_valid}), 130'd0);
    chk("post_rst_r_resp", r_resp, 130'd0);
    chk("post_rst_w_resp", 130'(w_resp), 130'd0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_write) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].mask, lat, code);
        chk($sformatf("v%0d_w_latency", i), 130'(lat), 130'd4);
        chk($sformatf("v%0d_bresp", i), 130'(code), 130'(vecs[i].exp_code));
      end else begin
        do_read(vecs[i].addr, lat, code, rdata);
        chk($sformatf("v%0d_r_latency", i), 130'(lat), 130'd4);
        chk($sformatf("v%0d_rresp", i), 130'(code), 130'(vecs[i].exp_code));
        chk($sformatf("v%0d_rdata", i), 130'(rdata), 130'(vecs[i].exp_rdata));
      end
    end

    // Write and read offered together: write goes first, read waits.
    w_req_valid = 1'b1; w_req = {32'h0000_0050, A5, 16'hFFFF};
    r_req_valid = 1'b1; r_req = 32'h0000_0050;
    #1;
    chk("both_w_req_ready", 130'(w_req_ready), 130'd1);
    chk("both_r_req_ready", 130'(r_req_ready), 130'd0);
    tick();
    w_req_valid = 1'b0;
    #1;
    chk("wwait_r_req_ready", 130'(r_req_ready), 130'd0);
    n = 0;
    while (!w_resp_valid && n < 50) begin tick(); n++; end
    chk("both_w_latency", 130'(n), 130'd4);
    chk("both_r_not_early", 130'(r_resp_valid), 130'd0);
    w_resp_ready = 1'b1;
    tick();
    w_resp_ready = 1'b0;
    #1;
    chk("pending_r_req_ready", 130'(r_req_ready), 130'd1);
    tick();
    r_req_valid = 1'b0;
    n = 0;
    while (!r_resp_valid && n < 50) begin tick(); n++; end
    chk("both_r_latency", 130'(n), 130'd4);
    chk("both_rdata", r_resp, {A5, 2'b00});

    // Hold the read response back for ten cycles.
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("bp_hold%0d", c), {r_resp_valid, r_resp}, {1'b1, A5, 2'b00});
    end
    r_resp_ready = 1'b1;
    tick();
    r_resp_ready = 1'b0;
    #1;
    chk("bp_released_valid", 130'(r_resp_valid), 130'd0);
    chk("bp_idle_readys", 130'({w_req_ready, r_req_ready}), 130'd3);

    // Reset while a write to line 3 is waiting.
    do_write(32'h0000_0030, K3, 16'hFFFF, lat, code);
    chk("k3_bresp", 130'(code), 130'd0);
    w_req_valid = 1'b1; w_req = {32'h0000_0030, ONES, 16'hFFFF};
    #1;
    tick();
    w_req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_readys", 130'({w_req_ready, r_req_ready}), 130'd0);
    tick();
    chk("midrst_valids", 130'({r_resp_valid, w_resp_valid}), 130'd0);
    chk("midrst_w_resp", 130'(w_resp), 130'd0);
    rst = 1'b0;
    #1;
    chk("midrst_idle", 130'({w_req_ready, r_req_ready}), 130'd3);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (w_resp_valid || r_resp_valid) seen = 1'b1;
    end
    chk("midrst_no_resp", 130'(seen), 130'd0);
    do_read(32'h0000_0030, lat, code, rdata);
    chk("midrst_rresp", 130'(code), 130'd0);
    chk("midrst_rdata", 130'(rdata), 130'(K3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
